// File: rtl/config_chain_loader.sv
// Serial configuration chain loader: takes host words over valid/ready, shifts them
// MSB-first onto the daisy-chained BLE shift registers with a divided, gated shift
// clock, and packs the bits leaving the chain tail into readback words.
module config_chain_loader #(
    parameter int unsigned CHAIN_LENGTH = 130,
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned CLK_DIV      = 2
) (
    input  logic                  clk,
    input  logic                  sys_reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] wr_word,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  config_data,
    output logic                  config_clk,
    output logic                  config_en,
    input  logic                  config_return,
    output logic [WORD_WIDTH-1:0] rd_word,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned SENT_W = $clog2(CHAIN_LENGTH + 1);
    localparam int unsigned WCNT_W = $clog2(WORD_WIDTH + 1);
    localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);

    localparam logic [SENT_W-1:0] SENT_LAST = SENT_W'(CHAIN_LENGTH);
    localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(WORD_WIDTH);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORD_WIDTH - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_PRE   = DIV_W'(CLK_DIV - 2);
    localparam bit                HAS_PRE   = (CLK_DIV >= 2);
    localparam bit                DIV_ONE   = (CLK_DIV == 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        SHIFT_LO,
        SHIFT_HI,
        FINISH
    } state_t;

    state_t                  state;
    logic [DIV_W-1:0]        div_cnt;
    logic [SENT_W-1:0]       bits_sent;
    logic [WCNT_W-1:0]       word_bits;
    logic [WORD_WIDTH-1:0]   shreg;
    logic [WORD_WIDTH-1:0]   rd_sh;
    logic [WCNT_W-1:0]       rd_cnt;

    logic                    last_div;
    logic [SENT_W-1:0]       sent_inc;
    logic [WCNT_W-1:0]       word_bits_inc;
    logic [WORD_WIDTH-1:0]   rd_sh_nxt;
    logic                    need_now;
    logic                    need_after_bit;
    logic [WCNT_W-1:0]       pad_shift;

    // Counter arithmetic and "host word needed" predicates used by the FSM.
    always_comb begin
        last_div       = (div_cnt == DIV_LAST);
        sent_inc       = bits_sent + SENT_W'(1);
        word_bits_inc  = word_bits + WCNT_W'(1);
        rd_sh_nxt      = (rd_sh << 1) | WORD_WIDTH'(config_return);
        need_now       = (word_bits == WCNT_FULL) && (bits_sent != SENT_LAST);
        need_after_bit = (word_bits_inc == WCNT_FULL) && (sent_inc != SENT_LAST);
        pad_shift      = WCNT_FULL - rd_cnt;
    end

    // Load sequencer: word fetch, bit serialisation, clock generation and readback.
    // wr_ready rises during the final high phase of a word so the next word can be
    // taken on the falling edge without stretching the bit period.
    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bits_sent   <= '0;
            word_bits   <= '0;
            shreg       <= '0;
            rd_sh       <= '0;
            rd_cnt      <= '0;
            wr_ready    <= 1'b0;
            config_data <= 1'b0;
            config_clk  <= 1'b0;
            config_en   <= 1'b0;
            rd_word     <= '0;
            rd_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= WAIT_WORD;
                        busy       <= 1'b1;
                        config_en  <= 1'b1;
                        wr_ready   <= 1'b1;
                        config_clk <= 1'b0;
                        div_cnt    <= '0;
                        bits_sent  <= '0;
                        word_bits  <= '0;
                        rd_cnt     <= '0;
                        rd_sh      <= '0;
                    end
                end

                WAIT_WORD: begin
                    wr_ready   <= 1'b1;
                    config_clk <= 1'b0;
                    if (wr_valid) begin
                        state       <= SHIFT_LO;
                        config_data <= wr_word[WORD_WIDTH-1];
                        shreg       <= wr_word << 1;
                        word_bits   <= '0;
                        div_cnt     <= '0;
                        wr_ready    <= 1'b0;
                    end
                end

                SHIFT_LO: begin
                    if (last_div) begin
                        state      <= SHIFT_HI;
                        config_clk <= 1'b1;
                        div_cnt    <= '0;
                        bits_sent  <= sent_inc;
                        word_bits  <= word_bits_inc;
                        rd_sh      <= rd_sh_nxt;
                        if (rd_cnt == WCNT_LAST) begin
                            rd_word  <= rd_sh_nxt;
                            rd_valid <= 1'b1;
                            rd_cnt   <= '0;
                        end else begin
                            rd_cnt <= rd_cnt + WCNT_W'(1);
                        end
                        if (DIV_ONE) begin
                            wr_ready <= need_after_bit;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                SHIFT_HI: begin
                    if (!last_div) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                        if (HAS_PRE && (div_cnt == DIV_PRE)) begin
                            wr_ready <= need_now;
                        end
                    end else begin
                        config_clk <= 1'b0;
                        div_cnt    <= '0;
                        if (bits_sent == SENT_LAST) begin
                            state       <= FINISH;
                            config_en   <= 1'b0;
                            config_data <= 1'b0;
                            wr_ready    <= 1'b0;
                            done        <= 1'b1;
                            if (rd_cnt != '0) begin
                                rd_word  <= rd_sh << pad_shift;
                                rd_valid <= 1'b1;
                            end
                        end else if (word_bits == WCNT_FULL) begin
                            if (wr_valid && wr_ready) begin
                                state       <= SHIFT_LO;
                                config_data <= wr_word[WORD_WIDTH-1];
                                shreg       <= wr_word << 1;
                                word_bits   <= '0;
                                wr_ready    <= 1'b0;
                            end else begin
                                state    <= WAIT_WORD;
                                wr_ready <= 1'b1;
                            end
                        end else begin
                            state       <= SHIFT_LO;
                            config_data <= shreg[WORD_WIDTH-1];
                            shreg       <= shreg << 1;
                        end
                    end
                end

                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: two instances (default 130/32/2 and 64/32/1), each
// driving a behavioural model of the BLE chain; expected readback words are queued
// when a load is issued and compared by a monitor whenever rd_valid pulses.
module tb_config_chain_loader;

    localparam int CL_A  = 130;
    localparam int DIV_A = 2;
    localparam int CL_B  = 64;
    localparam int DIV_B = 1;
    localparam int W     = 32;
    localparam int LIMIT = 4000;

    logic clk = 1'b0;
    logic sys_reset;

    logic          start_a, wr_valid_a, wr_ready_a, config_data_a, config_clk_a;
    logic          config_en_a, config_return_a, rd_valid_a, busy_a, done_a;
    logic [W-1:0]  wr_word_a, rd_word_a;
    logic          start_b, wr_valid_b, wr_ready_b, config_data_b, config_clk_b;
    logic          config_en_b, config_return_b, rd_valid_b, busy_b, done_b;
    logic [W-1:0]  wr_word_b, rd_word_b;

    logic [CL_A-1:0] chain_a;
    logic [CL_B-1:0] chain_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int edges[2];
    int hs[2];
    int dones[2];
    int viol[2];
    int last_edge[2];
    bit abort;

    logic [W-1:0]   stim_q[$];
    logic [W-1:0]   exp_rd_a[$];
    logic [W-1:0]   exp_rd_b[$];
    logic [255:0]   exp_chain;

    config_chain_loader #(.CHAIN_LENGTH(CL_A), .WORD_WIDTH(W), .CLK_DIV(DIV_A)) dut_a (
        .clk(clk), .sys_reset(sys_reset), .start(start_a), .wr_word(wr_word_a),
        .wr_valid(wr_valid_a), .wr_ready(wr_ready_a), .config_data(config_data_a),
        .config_clk(config_clk_a), .config_en(config_en_a), .config_return(config_return_a),
        .rd_word(rd_word_a), .rd_valid(rd_valid_a), .busy(busy_a), .done(done_a)
    );

    config_chain_loader #(.CHAIN_LENGTH(CL_B), .WORD_WIDTH(W), .CLK_DIV(DIV_B)) dut_b (
        .clk(clk), .sys_reset(sys_reset), .start(start_b), .wr_word(wr_word_b),
        .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .config_data(config_data_b),
        .config_clk(config_clk_b), .config_en(config_en_b), .config_return(config_return_b),
        .rd_word(rd_word_b), .rd_valid(rd_valid_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Tail of each chain feeds the loader's return input.
    assign config_return_a = chain_a[CL_A-1];
    assign config_return_b = chain_b[CL_B-1];

    always @(posedge clk) cyc++;

    // Chain models: bit 0 is the head BLE input, the top bit is the tail output.
    always @(posedge config_clk_a) begin
        if (config_en_a) begin
            chain_a = {chain_a[CL_A-2:0], config_data_a};
            if (edges[0] > 0 && (cyc - last_edge[0]) != 2 * DIV_A) viol[0]++;
            last_edge[0] = cyc;
            edges[0]++;
        end
    end

    always @(posedge config_clk_b) begin
        if (config_en_b) begin
            chain_b = {chain_b[CL_B-2:0], config_data_b};
            if (edges[1] > 0 && (cyc - last_edge[1]) != 2 * DIV_B) viol[1]++;
            last_edge[1] = cyc;
            edges[1]++;
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: handshakes, done pulses and readback words against the scoreboard.
    always @(negedge clk) begin
        if (!sys_reset && wr_valid_a && wr_ready_a) hs[0]++;
        if (done_a) dones[0]++;
        if (rd_valid_a) begin
            if (exp_rd_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_unexpected_a: got %0h expected no word", rd_word_a);
            end else begin
                check("rd_word_a", 256'(rd_word_a), 256'(exp_rd_a.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!sys_reset && wr_valid_b && wr_ready_b) hs[1]++;
        if (done_b) dones[1]++;
        if (rd_valid_b) begin
            if (exp_rd_b.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_unexpected_b: got %0h expected no word", rd_word_b);
            end else begin
                check("rd_word_b", 256'(rd_word_b), 256'(exp_rd_b.pop_front()));
            end
        end
    end

    // Reference: stream = words MSB-first truncated to the chain length; afterwards the
    // first streamed bit sits at the tail. Readback = old contents tail-first, packed
    // MSB-first, last word left-aligned and zero-filled.
    function automatic void compute_expect(input int inst, input int cl, input logic [255:0] old);
        bit s[$];
        bit r[$];
        logic [W-1:0] wd;
        int nw;
        s = {};
        r = {};
        foreach (stim_q[k]) begin
            wd = stim_q[k];
            for (int b = W - 1; b >= 0; b--) if (s.size() < cl) s.push_back(wd[b]);
        end
        exp_chain = '0;
        for (int i = 0; i < cl; i++) exp_chain[i] = s[cl-1-i];
        for (int k = 0; k < cl; k++) r.push_back(old[cl-1-k]);
        nw = (cl + W - 1) / W;
        for (int j = 0; j < nw; j++) begin
            wd = '0;
            for (int b = 0; b < W; b++) if (j * W + b < cl) wd[W-1-b] = r[j*W+b];
            if (inst == 0) exp_rd_a.push_back(wd);
            else exp_rd_b.push_back(wd);
        end
    endfunction

    task automatic set_start(input int inst, input logic v);
        if (inst == 0) start_a = v;
        else start_b = v;
    endtask

    task automatic set_wr(input int inst, input logic [W-1:0] w, input logic v);
        if (inst == 0) begin wr_word_a = w; wr_valid_a = v; end
        else begin wr_word_b = w; wr_valid_b = v; end
    endtask

    function automatic logic ready_of(input int inst);
        return (inst == 0) ? wr_ready_a : wr_ready_b;
    endfunction
    function automatic logic done_of(input int inst);
        return (inst == 0) ? done_a : done_b;
    endfunction
    function automatic logic cclk_of(input int inst);
        return (inst == 0) ? config_clk_a : config_clk_b;
    endfunction
    function automatic logic en_of(input int inst);
        return (inst == 0) ? config_en_a : config_en_b;
    endfunction
    function automatic logic busy_of(input int inst);
        return (inst == 0) ? busy_a : busy_b;
    endfunction

    // Host side: present words back to back, optionally withholding one word for a while.
    task automatic drive_words(input int inst, input int stall_word, input int stall_len);
        int t;
        bit got;
        int e0;
        int bad_clk;
        for (int i = 0; i < stim_q.size(); i++) begin
            set_wr(inst, stim_q[i], 1'b1);
            got = 0;
            for (t = 0; t < LIMIT && !got && !abort; t++) begin
                @(negedge clk);
                got = ready_of(inst);
            end
            if (!got) begin
                if (!abort) begin
                    n_cmp++; n_bad++;
                    $display("FAIL hs_timeout: word %0d got no ready, expected ready", i);
                end
                set_wr(inst, '0, 1'b0);
                return;
            end
            @(posedge clk); #1;
            set_wr(inst, '0, 1'b0);
            if (i == stall_word && i + 1 < stim_q.size()) begin
                got = 0;
                for (t = 0; t < LIMIT && !got; t++) begin
                    @(negedge clk);
                    got = ready_of(inst);
                end
                e0 = edges[inst];
                bad_clk = 0;
                repeat (stall_len) begin
                    @(negedge clk);
                    if (cclk_of(inst) || !en_of(inst)) bad_clk++;
                end
                check("stall_ready_seen", 256'(got), 256'(1));
                check("stall_clk_quiet", 256'(bad_clk), 256'(0));
                check("stall_no_edges", 256'(edges[inst] - e0), 256'(0));
                @(posedge clk); #1;
            end
        end
    endtask

    // Waits for the end of the load (or fires a reset part-way through it).
    task automatic control(input int inst, input bit poke, input int reset_edge);
        int t;
        bit seen;
        seen = 0;
        if (reset_edge > 0) begin
            for (t = 0; t < LIMIT && edges[inst] < reset_edge; t++) @(negedge clk);
            check("edges_reached_before_reset", 256'(edges[inst] >= reset_edge), 256'(1));
            sys_reset = 1'b1;
            #1;
            check("reset_outputs_async", 256'({wr_ready_a, config_data_a, config_clk_a,
                  config_en_a, rd_word_a, rd_valid_a, busy_a, done_a}), 256'(0));
            abort = 1'b1;
            repeat (3) @(negedge clk);
            sys_reset = 1'b0;
        end else begin
            for (t = 0; t < LIMIT && !seen; t++) begin
                @(negedge clk);
                seen = done_of(inst);
            end
            if (!seen) begin
                n_cmp++; n_bad++;
                $display("FAIL done_timeout: got no done, expected done pulse");
            end else if (poke) begin
                set_start(inst, 1'b1);
                @(posedge clk); #1;
                set_start(inst, 1'b0);
            end
        end
    endtask

    task automatic poke_mid(input int inst, input bit poke);
        if (poke) begin
            repeat (60) @(posedge clk);
            #1;
            set_start(inst, 1'b1);
            @(posedge clk); #1;
            set_start(inst, 1'b0);
        end
    endtask

    task automatic run_load(input int inst, input int stall_word, input int stall_len,
                            input bit poke, input int reset_edge);
        int cl;
        int nw;
        logic [255:0] old;
        logic [255:0] cur;
        cl = (inst == 0) ? CL_A : CL_B;
        nw = (cl + W - 1) / W;
        stim_q.delete();
        for (int i = 0; i < nw; i++) stim_q.push_back($urandom());
        old = (inst == 0) ? 256'(chain_a) : 256'(chain_b);
        compute_expect(inst, cl, old);
        edges[inst] = 0; hs[inst] = 0; dones[inst] = 0; viol[inst] = 0;
        abort = 1'b0;
        @(posedge clk); #1;
        set_start(inst, 1'b1);
        @(posedge clk); #1;
        set_start(inst, 1'b0);
        check("busy_after_start", 256'(busy_of(inst)), 256'(1));
        fork
            drive_words(inst, stall_word, stall_len);
            control(inst, poke, reset_edge);
            poke_mid(inst, poke);
        join
        if (reset_edge > 0) begin
            if (inst == 0) exp_rd_a.delete();
            else exp_rd_b.delete();
            return;
        end
        repeat (10) @(negedge clk);
        cur = (inst == 0) ? 256'(chain_a) : 256'(chain_b);
        check("edge_count", 256'(edges[inst]), 256'(cl));
        check("handshakes", 256'(hs[inst]), 256'(nw));
        check("done_pulses", 256'(dones[inst]), 256'(1));
        check("idle_after_load", 256'({busy_of(inst), en_of(inst), cclk_of(inst)}), 256'(0));
        check("chain_contents", cur, exp_chain);
        check("readback_left", 256'((inst == 0) ? exp_rd_a.size() : exp_rd_b.size()), 256'(0));
        if (stall_len == 0) check("edge_spacing_viol", 256'(viol[inst]), 256'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_reset = 1'b1;
        start_a = 1'b0; wr_valid_a = 1'b0; wr_word_a = '0;
        start_b = 1'b0; wr_valid_b = 1'b0; wr_word_b = '0;
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            edges[i] = 0; hs[i] = 0; dones[i] = 0; viol[i] = 0; last_edge[i] = 0;
        end
        chain_a = CL_A'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        chain_b = CL_B'({$urandom(), $urandom()});
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_a", 256'({wr_ready_a, config_data_a, config_clk_a, config_en_a,
              rd_word_a, rd_valid_a, busy_a, done_a}), 256'(0));
        check("reset_outputs_b", 256'({wr_ready_b, config_data_b, config_clk_b, config_en_b,
              rd_word_b, rd_valid_b, busy_b, done_b}), 256'(0));
        @(negedge clk);
        sys_reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outputs_a", 256'({wr_ready_a, config_clk_a, config_en_a, busy_a, done_a}), 256'(0));

        // Full load with words always available.
        run_load(0, -1, 0, 1'b0, 0);
        // Known pattern preloaded, readback must return it tail-first.
        chain_a = {5{32'hDEADBEEF}};
        run_load(0, -1, 0, 1'b0, 0);
        // Host withholds the third word for 20 cycles.
        run_load(0, 1, 20, 1'b0, 0);
        // Stray start pulses mid-load and during FINISH.
        run_load(0, -1, 0, 1'b1, 0);
        // Reset after 40 edges, then a clean reload.
        run_load(0, -1, 0, 1'b0, 40);
        check("idle_after_reset", 256'({busy_a, config_en_a, config_clk_a, wr_ready_a}), 256'(0));
        run_load(0, -1, 0, 1'b0, 0);
        // Randomised stall position and length.
        for (int k = 0; k < 2; k++) begin
            run_load(0, int'($urandom_range(0, 3)), int'($urandom_range(1, 30)), 1'b0, 0);
        end
        // Exact multiple of the word width, single-cycle half periods.
        run_load(1, -1, 0, 1'b0, 0);
        run_load(1, 0, 5, 1'b0, 0);
        run_load(1, -1, 0, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
